// File: rtl/vend_pkg.sv
// Encodings shared by the coin feeder and the vending FSM it drives.
package vend_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_COIN  = 5'b00010,
      ST_GAP   = 5'b00100,
      ST_DRAIN = 5'b01000,
      ST_DONE  = 5'b10000
   } state_e;

   typedef enum logic [1:0] {
      COIN_NONE = 2'd0,
      COIN_1    = 2'd1,
      COIN_2    = 2'd2
   } coin_e;

   localparam int         DRAIN_LEN    = 2;
   localparam int         CNT_W        = 4;
   localparam logic [3:0] VEND_CNT_MAX = 4'd15;
   localparam logic [5:0] CHG_SUM_MAX  = 6'd63;

endpackage

// File: rtl/coin_feeder.sv
// Coin feeder: first coin 1 cycle after acceptance, pulses spaced by GAP idle cycles, done after a 2-cycle drain.
// pay_rdy only in IDLE; requests arriving while busy are dropped, not queued.
module coin_feeder
   import vend_pkg::*;
#(
   parameter int GAP   = 1,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AMT_W-1:0] pay_amt,
   input  logic             pay_mode,
   input  logic             pay_vld,
   output logic             pay_rdy,
   output logic [1:0]       coin,
   input  logic [1:0]       vend_chg,
   input  logic             vend_vld,
   output logic             done,
   output logic [3:0]       vend_cnt,
   output logic [5:0]       chg_sum
);

   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LEN - 1);

   state_e           state_q, state_d;
   logic [AMT_W-1:0] remain_q, remain_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [5:0]       chg_q, chg_d;
   coin_e            coin_c;
   logic [6:0]       chg_add;

   assign chg_add = {1'b0, chg_q} + {5'b0, vend_chg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         mode_q   <= 1'b0;
         gap_q    <= '0;
         cnt_q    <= '0;
         chg_q    <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         mode_q   <= mode_d;
         gap_q    <= gap_d;
         cnt_q    <= cnt_d;
         chg_q    <= chg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      mode_d   = mode_q;
      gap_d    = gap_q;
      cnt_d    = cnt_q;
      chg_d    = chg_q;
      coin_c   = COIN_NONE;
      pay_rdy  = 1'b0;
      done     = 1'b0;

      // Dispenses count in every busy state, including the drain and done cycles.
      if (state_q != ST_IDLE && vend_vld) begin
         cnt_d = (cnt_q == VEND_CNT_MAX) ? VEND_CNT_MAX : cnt_q + 4'd1;
         chg_d = (chg_add > {1'b0, CHG_SUM_MAX}) ? CHG_SUM_MAX : chg_add[5:0];
      end

      case (state_q)
         ST_IDLE: begin
            pay_rdy = 1'b1;
            if (pay_vld) begin
               remain_d = pay_amt;
               mode_d   = pay_mode;
               cnt_d    = '0;
               chg_d    = '0;
               if (pay_amt == '0) begin
                  state_d = ST_DRAIN;
                  gap_d   = DRAIN_LOAD;
               end else begin
                  state_d = ST_COIN;
               end
            end
         end
         ST_COIN: begin
            if (mode_q && ((remain_q >> 1) != '0)) begin
               coin_c   = COIN_2;
               remain_d = remain_q - AMT_W'(2);
            end else begin
               coin_c   = COIN_1;
               remain_d = remain_q - AMT_W'(1);
            end
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               if (remain_q != '0) begin
                  state_d = ST_COIN;
               end else begin
                  state_d = ST_DRAIN;
                  gap_d   = DRAIN_LOAD;
               end
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         ST_DRAIN: begin
            if (gap_q == '0) state_d = ST_DONE;
            else             gap_d   = gap_q - 1'b1;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign coin     = coin_c;
   assign vend_cnt = cnt_q;
   assign chg_sum  = chg_q;

endmodule

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 SHALL have parameter GAP, default 1: idle cycles inserted after every coin pulse, legal range 1..15.
REQ-002 SHALL have parameter AMT_W, default 4: width of the payment amount.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pay_amt, input, AMT_W bits: total yuan to insert.
REQ-006 SHALL have port pay_mode, input, 1 bit: 0 = 1-yuan coins only; 1 = prefer 2-yuan coins.
REQ-007 SHALL have port pay_vld, input, 1 bit: payment request valid.
REQ-008 SHALL have port pay_rdy, output, 1 bit: feeder can accept a request.
REQ-009 SHALL have port coin, output, 2 bits: coin pulse to the vending FSM; 0 = none, 1 = 1 yuan, 2 = 2 yuan; 3 never driven.
REQ-010 SHALL have port vend_chg, input, 2 bits: change reported by the vending FSM.
REQ-011 SHALL have port vend_vld, input, 1 bit: vending FSM dispense pulse.
REQ-012 SHALL have port done, output, 1 bit: one-cycle session-complete pulse.
REQ-013 SHALL have port vend_cnt, output, 4 bits: dispenses observed during the session, valid while done is high.
REQ-014 SHALL have port chg_sum, output, 6 bits: change accumulated during the session, valid while done is high.

Function
REQ-015 SHALL implement states IDLE, COIN, GAP, DRAIN, DONE.
REQ-016 SHALL hold pay_rdy high only in IDLE; a request is accepted on a cycle where pay_vld and pay_rdy are both high.
REQ-017 On acceptance, SHALL latch pay_amt into remain and pay_mode into mode, clear vend_cnt and chg_sum, then go to COIN; if pay_amt is 0, SHALL go to DRAIN instead.
REQ-018 In COIN, SHALL drive coin for exactly one cycle:
- 2 if mode is 1 and remain is 2 or more;
- otherwise 1.
REQ-019 In COIN, SHALL decrement remain by the coin value, then go to GAP.
REQ-020 In GAP, SHALL drive coin to 0 for GAP cycles, using a down-counter; then go to COIN if remain is nonzero, else go to DRAIN.
REQ-021 DRAIN SHALL last 2 cycles with coin at 0, so a late vend_vld is still captured; then go to DONE.
REQ-022 DONE SHALL pulse done for 1 cycle, then return to IDLE; vend_cnt and chg_sum SHALL hold until the next acceptance.
REQ-023 In every non-IDLE state, a vend_vld high SHALL increment vend_cnt, saturating at 15, and add vend_chg to chg_sum, saturating at 63.
REQ-024 vend_vld in IDLE SHALL be ignored.
REQ-025 pay_vld while busy SHALL be ignored; requests are not queued.
REQ-026 Request-to-first-coin latency SHALL be 1 cycle: coin is nonzero in the cycle after acceptance.
REQ-027 Coin pulses SHALL be separated by exactly GAP zero cycles.

Reset
REQ-028 While rst is high, SHALL force: state IDLE, coin 0, pay_rdy 1, done 0, vend_cnt 0, chg_sum 0, remain 0, gap counter 0.
REQ-029 Reset asserted mid-session SHALL abort immediately: no further coin pulses, and no done pulse for that session.

Structure
REQ-030 State encoding (one-hot, 5 bits), coin codes (COIN_NONE, COIN_1, COIN_2) and the 2-cycle DRAIN length SHALL live in a shared package vend_pkg, which is also used by the vending FSM.
REQ-031 SHALL be a single module with no sub-modules; the gap down-counter is inline.

Verification
REQ-032 Scenario 1: pay_amt=3, mode=0, GAP=1 -> coin sequence 1,0,1,0,1; one vend_vld with vend_chg=0 -> done shows vend_cnt=1, chg_sum=0.
REQ-033 Scenario 2: pay_amt=3, mode=1 -> coin sequence 2,0,1; done pulses 1+1+2 cycles after the last coin pulse.
REQ-034 Scenario 3: pay_amt=4, mode=1, with the vending FSM returning change 1 -> coin sequence 2,0,2; vend_cnt=1, chg_sum=1.
REQ-035 Scenario 4: pay_amt=0 -> no coin pulses; done pulses 3 cycles after acceptance with vend_cnt=0 and chg_sum=0.
REQ-036 Scenario 5: rst raised between the first and second coin of pay_amt=3 -> coin stays 0, done never pulses, pay_rdy=1 after reset is released.
REQ-037 Scenario 6: pay_vld held high throughout a session -> exactly one session runs; the next request is accepted only in the cycle after done.
